// File: rtl/sram_like_responder.sv
// In-order sram-like data-bus responder backed by a word RAM.
// Each accepted request completes a fixed LATENCY after acceptance; an earlier request still in flight can delay it further.
module sram_like_responder #(
    parameter int AW      = 10,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    input  logic        stall_addr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef struct packed {
        logic          wr;
        logic [1:0]    size;
        logic [AW-1:0] idx;
        logic [1:0]    lo;
        logic [31:0]   wdata;
    } ent_t;

    ent_t          ent_q [DEPTH];
    logic [CW-1:0] cnt_q [DEPTH];
    logic [31:0]   mem   [2**AW];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          dok_q;
    logic [31:0]   rdata_q, rdata_d;

    ent_t       in_ent, cur;
    logic       full, accept, hd_vld, hd_rdy, byp, pop, push;
    logic [3:0] be;
    logic       unused_addr;

    assign unused_addr = ^data_addr[31:AW+2];

    assign in_ent = '{wr: data_wr, size: data_size, idx: data_addr[AW+1:2],
                      lo: data_addr[1:0], wdata: data_wdata};

    assign full         = (count_q == (PW+1)'(DEPTH));
    assign data_addr_ok = !full && !stall_addr;
    assign accept       = data_req && data_addr_ok;

    // Head pops on the edge its counter would reach zero, giving LATENCY-1 edges of wait.
    assign hd_vld = (count_q != '0);
    assign hd_rdy = hd_vld && (cnt_q[head_q] <= CW'(1));
    // With LATENCY=1 a request into an empty queue completes on its accepting edge.
    assign byp  = (LATENCY == 1) && !hd_vld && accept;
    assign pop  = hd_rdy || byp;
    assign push = accept && !byp;
    assign cur  = byp ? in_ent : ent_q[head_q];

    always_comb begin
        be = 4'b0000;
        case (cur.size)
            2'd0:    be = 4'b0001 << cur.lo;
            2'd1:    be = cur.lo[1] ? 4'b1100 : 4'b0011;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        head_d  = head_q + PW'(hd_rdy);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + (PW+1)'(push) - (PW+1)'(hd_rdy);
        rdata_d = rdata_q;
        if (pop) rdata_d = cur.wr ? 32'h0 : mem[cur.idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dok_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dok_q   <= pop;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CW'(1);
        if (push) begin
            ent_q[tail_q] <= in_ent;
            cnt_q[tail_q] <= CW'(LATENCY - 1);
        end
    end

    // RAM is not cleared by reset; a commit landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst && pop && cur.wr)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[cur.idx][8*b +: 8] <= cur.wdata[8*b +: 8];
    end

    assign data_data_ok = dok_q;
    assign data_rdata   = rdata_q;
endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: instance a (LATENCY=2) and instance b (LATENCY=8) share one stimulus stream.
module tb_sram_like_responder;
    logic        clk = 1'b0;
    logic        rst, req, wr, stall;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        ok_a, ok_b, dok_a, dok_b;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] rd;
    int          k;

    always #5 clk = ~clk;

    sram_like_responder #(.AW(10), .DEPTH(4), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .data_req(req), .data_wr(wr), .data_size(sz),
        .data_addr(addr), .data_wdata(wdata), .data_rdata(rdata_a),
        .data_addr_ok(ok_a), .data_data_ok(dok_a), .stall_addr(stall));

    sram_like_responder #(.AW(10), .DEPTH(4), .LATENCY(8)) dut_b (
        .clk(clk), .rst(rst), .data_req(req), .data_wr(wr), .data_size(sz),
        .data_addr(addr), .data_wdata(wdata), .data_rdata(rdata_b),
        .data_addr_ok(ok_b), .data_data_ok(dok_b), .stall_addr(stall));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after checking the pulse is one cycle wide.
    task automatic do_req(input bit sel, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdo, output int ko);
        int n = 0;
        req = 1'b1; wr = w; sz = s; addr = a; wdata = d;
        #1;
        while (!(sel ? ok_b : ok_a) && n < 20) begin
            @(posedge clk); #2; n++;
        end
        chk("accept", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        ko = 0;
        while (!(sel ? dok_b : dok_a) && ko < 20) begin
            @(posedge clk); #1; ko++;
        end
        rdo = sel ? rdata_b : rdata_a;
        @(posedge clk); #1;
        chk("pulse_width", 32'(sel ? dok_b : dok_a), 32'd0);
    endtask

    task automatic do_rst;
        req = 1'b0; stall = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; sz = 2'd2; addr = '0; wdata = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_addr_ok_a", 32'(ok_a), 32'd1);
        chk("rst_dok_a", 32'(dok_a), 32'd0);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_addr_ok_b", 32'(ok_b), 32'd1);
        chk("rst_dok_b", 32'(dok_b), 32'd0);

        // Full-word write then read back
        do_req(1'b0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd, k);
        chk("wr_lat", 32'(k), 32'd1);
        chk("wr_rdata", rd, 32'h0);
        do_req(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, rd, k);
        chk("rd_lat", 32'(k), 32'd1);
        chk("rd_word", rd, 32'hDEADBEEF);

        // Partial writes
        do_req(1'b0, 1'b1, 2'd0, 32'h11, 32'h0000AB00, rd, k);
        do_req(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, rd, k);
        chk("rd_byte", rd, 32'hDEADABEF);
        do_req(1'b0, 1'b1, 2'd1, 32'h12, 32'h56780000, rd, k);
        do_req(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, rd, k);
        chk("rd_half", rd, 32'h5678ABEF);
        do_req(1'b0, 1'b1, 2'd3, 32'h10, 32'h11111111, rd, k);
        chk("sz3_lat", 32'(k), 32'd1);
        do_req(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, rd, k);
        chk("rd_sz3", rd, 32'h5678ABEF);

        // Back-to-back reads of preloaded words 1..4
        for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 2'd2, 32'(i*4), 32'(i+1), rd, k);
        req = 1'b1; wr = 1'b0; sz = 2'd2; addr = 32'h0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i < 4) chk("b2b_addr_ok", 32'(ok_a), 32'd1);
            @(posedge clk); #1;
            if (i < 3) addr = 32'((i + 1) * 4);
            else req = 1'b0;
            chk("b2b_dok", 32'(dok_a), 32'(i >= 1 && i <= 4));
            if (i >= 1 && i <= 4) chk("b2b_rdata", rdata_a, 32'(i));
        end

        // Backpressure
        stall = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_addr_ok", 32'(ok_a), 32'd0);
            @(posedge clk); #1;
            chk("stall_dok", 32'(dok_a), 32'd0);
        end
        stall = 1'b0;
        #1;
        chk("release_addr_ok", 32'(ok_a), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        k = 0;
        while (!dok_a && k < 20) begin @(posedge clk); #1; k++; end
        chk("release_lat", 32'(k), 32'd1);
        chk("release_rdata", rdata_a, 32'd3);

        // Queue full on the LATENCY=8 instance
        do_rst();
        req = 1'b1; wr = 1'b0; addr = 32'h0;
        for (int i = 0; i < 9; i++) begin
            logic acc;
            #1;
            acc = ok_b;
            chk("full_addr_ok", 32'(acc), 32'(i < 4 || i == 8));
            @(posedge clk); #1;
            if (acc) addr = addr + 32'd4;
            if (i == 8) req = 1'b0;
            chk("full_dok", 32'(dok_b), 32'(i >= 7));
        end
        repeat (20) @(posedge clk);
        #1;

        // Reset with two reads outstanding
        do_rst();
        do_req(1'b1, 1'b1, 2'd2, 32'h10, 32'hCAFEF00D, rd, k);
        chk("b_wr_lat", 32'(k), 32'd7);
        req = 1'b1; wr = 1'b0; addr = 32'h14;
        @(posedge clk); #1;
        addr = 32'h18;
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_dok_a", 32'(dok_a), 32'd0);
        chk("mid_rst_dok_b", 32'(dok_b), 32'd0);
        chk("mid_rst_rdata_b", rdata_b, 32'h0);
        chk("mid_rst_addr_ok_b", 32'(ok_b), 32'd1);
        begin
            int seen = 0;
            repeat (10) begin
                @(posedge clk); #1;
                if (dok_b || dok_a) seen++;
            end
            chk("mid_rst_no_dok", 32'(seen), 32'd0);
        end
        do_req(1'b1, 1'b0, 2'd2, 32'h10, 32'h0, rd, k);
        chk("post_rst_lat", 32'(k), 32'd7);
        chk("post_rst_rdata", rd, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
